// File: rtl/prng64_pkg.sv
// prng64_pkg: shared word type, tempering shift amounts and the xorshift temper function.
package prng64_pkg;
    typedef logic [63:0] prng_word_t;

    localparam int TEMPER_SH_A = 29;
    localparam int TEMPER_SH_B = 17;
    localparam int TEMPER_SH_C = 43;

    function automatic prng_word_t temper(prng_word_t w);
        prng_word_t a;
        prng_word_t b;
        a = w ^ (w >> TEMPER_SH_A);
        b = a ^ (a << TEMPER_SH_B);
        return b ^ (b >> TEMPER_SH_C);
    endfunction
endpackage

// File: rtl/prng64_packer_if.sv
// prng64_packer_if: generator-pair input strobe and the 64-bit valid/ready output stream.
interface prng64_packer_if;
    import prng64_pkg::*;
    logic [31:0] lcg1_in;
    logic [31:0] lcg2_in;
    logic        in_valid;
    prng_word_t  out_data;
    logic        out_valid;
    logic        out_ready;
    modport master (output lcg1_in, lcg2_in, in_valid, out_ready, input out_data, out_valid);
    modport slave (input lcg1_in, lcg2_in, in_valid, out_ready, output out_data, out_valid);
endinterface

// File: rtl/prng_fifo.sv
// prng_fifo: first-word-fall-through synchronous FIFO with occupancy output.
module prng_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             pop_ok;

    always_comb begin
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        level_d  = level_q + LW'(push) - LW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign level = level_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/prng64_packer.sv
// prng64_packer: packs LCG pairs into 64-bit words, optionally tempers them,
// and buffers them in a FIFO behind a valid/ready stream with drop statistics.
module prng64_packer
    import prng64_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TEMPER_EN  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr_stat,
    prng64_packer_if.slave                s,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   drop_count
);
    prng_word_t  s1_w_q, s1_w_d, s2_w_q, s2_w_d;
    logic        s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic        ovf_q, ovf_d;
    logic [15:0] drop_q, drop_d;
    logic        full, empty, pop, push, drop;

    always_comb begin
        s1_v_d = s.in_valid;
        s1_w_d = s.in_valid ? {s.lcg1_in, s.lcg2_in} : s1_w_q;
        s2_v_d = s1_v_q;
        s2_w_d = s1_v_q ? ((TEMPER_EN != 0) ? temper(s1_w_q) : s1_w_q) : s2_w_q;
        pop    = !empty && s.out_ready;
        push   = s2_v_q && (!full || pop);
        drop   = s2_v_q && full && !pop;
        ovf_d  = clr_stat ? 1'b0 : (ovf_q | drop);
        drop_d = clr_stat ? 16'h0 : drop_q + 16'(drop && drop_q != 16'hFFFF);
    end

    // The pipeline never stalls; back-pressure is absorbed only by the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_w_q <= '0;
            s1_v_q <= 1'b0;
            s2_w_q <= '0;
            s2_v_q <= 1'b0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            s1_w_q <= s1_w_d;
            s1_v_q <= s1_v_d;
            s2_w_q <= s2_w_d;
            s2_v_q <= s2_v_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    prng_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (s2_w_q),
        .dout  (s.out_data),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign s.out_valid = !empty;
    assign overflow    = ovf_q;
    assign drop_count  = drop_q;
endmodule
